sub_bytes_sched: RTL and testbench
==================================

# sub_bytes_sched

Time-multiplexed SubBytes scheduler sharing one 4-S-box bank (32 bits/cycle) between two requesters: the round datapath (full 128-bit state, four column passes) and the key-expansion SubWord path (one 32-bit word, one pass). It buffers each request, grants the bank one word per cycle, writes S-box results back in place and returns registered results with done pulses. It replaces the 16-S-box SubBytes array in area-constrained builds. The bank itself (4 SBox instances) sits outside this block on SboxIn/SboxOut.

## Interface
- KEY_PRIORITY, 1, 1: a pending key word wins the bank over a state column; 0: a state column wins and the key waits until the state request completes.
- Clk  in  1  clock, all state on rising edge.
- Rst  in  1  asynchronous, active-high reset.
- StateStart  in  1  request pulse; accepted only when StateReady=1.
- StateIn  in  128  state captured at acceptance; column 0 = [127:96] … column 3 = [31:0].
- StateReady  out  1  = !state-busy.
- StateDone  out  1  one-cycle pulse; StateOut valid from this cycle.
- StateOut  out  128  substituted state; holds until the next accepted StateStart.
- KeyStart  in  1  request pulse; accepted only when KeyReady=1.
- KeyIn  in  32  word captured at acceptance.
- KeyReady  out  1  = !key-busy.
- KeyDone  out  1  one-cycle pulse; KeyOut valid from this cycle.
- KeyOut  out  32  substituted word; holds until the next KeyDone.
- SboxIn  out  32  word presented to the bank; 0 when no grant.
- SboxOut  in  32  combinational bank result for SboxIn in the same cycle.
- GrantState  out  1  the bank serves a state column this cycle.
- GrantKey  out  1  the bank serves the key word this cycle.

## Operation
- Registers: StBusy, Col[1:0], StBuf[127:0], KeyBusy, KeyBuf[31:0], KeyOut, StateDone, KeyDone.
- StateOut is driven from StBuf.
- Accept state: when StateStart && !StBusy, do StBuf<=StateIn, StBusy<=1, Col<=0. If StBusy=1, StateStart is ignored with no effect.
- Accept key: when KeyStart && !KeyBusy, do KeyBuf<=KeyIn, KeyBusy<=1. If KeyBusy=1, KeyStart is ignored.
- Arbitration is combinational from the registered busy flags only. A request accepted in cycle n can first be granted in cycle n+1.
  - Only one busy: grant it.
  - Both busy: grant KeyBusy if KEY_PRIORITY=1, otherwise grant StBusy.
  - GrantState and GrantKey are never both 1.
- State grant: SboxIn = StBuf column Col. At the edge, that column <= SboxOut and Col<=Col+1. If Col==3, StBusy<=0 and StateDone<=1.
- Key grant: SboxIn = KeyBuf. At the edge, KeyOut<=SboxOut, KeyBusy<=0 and KeyDone<=1.
- Done pulses deassert on the following edge unless re-set.
- A new acceptance can occur in the same cycle its Done pulse is high, because Ready is already 1 then.
- Reset (asynchronous, any time) clears every register and output to 0:
  - StateReady=KeyReady=1; SboxIn=0; no grants.
  - An in-flight request is aborted and produces no Done pulse.

## Timing
- StateStart sampled at edge k, no contention: columns served in cycles k+1..k+4; StateDone high in cycle k+5.
- KeyStart sampled at edge k, no contention: grant in cycle k+1; KeyDone high in cycle k+2.
- Back-to-back keys: key grants occur at most every other cycle.
- With KEY_PRIORITY=1: each key steal delays the state request by 1 cycle. StateDone is guaranteed by cycle k+9.
- With KEY_PRIORITY=0: a key accepted during a state pass is granted the cycle after StBusy falls.
- Simultaneous StateStart and KeyStart at edge k, KEY_PRIORITY=1: GrantKey in k+1, KeyDone in k+2; state columns in k+2..k+5; StateDone in k+6.

## Test plan
- Bench connects 4 real AES S-boxes to SboxIn/SboxOut.
- Reset, then StateStart with StateIn=128'h0 -> StateDone exactly 5 cycles later, StateOut=128'h6363…63; GrantState high for 4 consecutive cycles.
- KeyStart with KeyIn=32'h000102_53 -> KeyDone 2 cycles later, KeyOut=32'h637C77ED; StateReady stays 1 throughout.
- Same-edge StateStart (StateIn=all 8'hFF) and KeyStart (KeyIn=32'h00000000), KEY_PRIORITY=1 -> KeyDone at +2 with KeyOut=32'h63636363; StateDone at +6 with StateOut all 8'h16. Repeat with KEY_PRIORITY=0 -> StateDone at +5, KeyDone at +6.
- KeyStart pulsed every cycle during a state pass -> keys are granted on alternate cycles; StateDone arrives by +9 with the correct result; StateStart/KeyStart pulses while busy are ignored, so the buffers are unchanged.
- Rst asserted mid-pass, after 2 columns -> all outputs 0 immediately (asynchronously), no StateDone afterwards; a fresh request then completes normally at +5.

Source files
------------

// File: rtl/sub_bytes_sched.sv
// sub_bytes_sched: shares one 32-bit S-box bank between the round state (4 column passes) and key SubWord.
module sub_bytes_sched #(
    parameter bit KEY_PRIORITY = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         state_start,
    input  logic [127:0] state_in,
    output logic         state_ready,
    output logic         state_done,
    output logic [127:0] state_out,
    input  logic         key_start,
    input  logic [31:0]  key_in,
    output logic         key_ready,
    output logic         key_done,
    output logic [31:0]  key_out,
    output logic [31:0]  sbox_in,
    input  logic [31:0]  sbox_out,
    output logic         grant_state,
    output logic         grant_key
);
    logic         st_busy;
    logic         key_busy;
    logic [1:0]   col;
    logic [127:0] st_buf;
    logic [31:0]  key_buf;
    assign state_ready = !st_busy;
    assign key_ready   = !key_busy;
    assign state_out   = st_buf;
    // column 0 sits in the top word, so the bit offset is (3-col)*32
    always_comb begin
        grant_key   = key_busy && (KEY_PRIORITY || !st_busy);
        grant_state = st_busy && !grant_key;
        sbox_in     = grant_state ? st_buf[{~col, 5'b0} +: 32] : grant_key ? key_buf : 32'h0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_busy    <= 1'b0;
            key_busy   <= 1'b0;
            col        <= 2'd0;
            st_buf     <= 128'h0;
            key_buf    <= 32'h0;
            key_out    <= 32'h0;
            state_done <= 1'b0;
            key_done   <= 1'b0;
        end else begin
            state_done <= grant_state && col == 2'd3;
            key_done   <= grant_key;
            if (state_start && !st_busy) begin
                st_buf  <= state_in;
                st_busy <= 1'b1;
                col     <= 2'd0;
            end else if (grant_state) begin
                st_buf[{~col, 5'b0} +: 32] <= sbox_out;
                col <= col + 2'd1;
                if (col == 2'd3) st_busy <= 1'b0;
            end
            if (key_start && !key_busy) begin
                key_buf  <= key_in;
                key_busy <= 1'b1;
            end else if (grant_key) begin
                key_out  <= sbox_out;
                key_busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sub_bytes_sched.sv
// tb_sub_bytes_sched: drives a key-priority and a state-priority instance, each with its own AES S-box bank.
module tb_sub_bytes_sched;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ss = 1'b0;
    logic         ks = 1'b0;
    logic [127:0] si = '0;
    logic [31:0]  ki = '0;
    logic         sr1, sd1, kr1, kd1, gs1, gk1;
    logic         sr0, sd0, kr0, kd0, gs0, gk0;
    logic [127:0] so1, so0;
    logic [31:0]  ko1, ko0, sbi1, sbi0, sbo1, sbo0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = xt(a);
        end
        return p;
    endfunction

    // AES S-box from its definition: GF(2^8) inverse followed by the affine map
    function automatic logic [7:0] sb(input logic [7:0] b);
        logic [7:0] inv = 8'h00;
        logic [7:0] r, s;
        for (int x = 1; x < 256; x++)
            if (gmul(b, x[7:0]) == 8'h01) inv = x[7:0];
        r = inv;
        s = inv;
        for (int i = 0; i < 4; i++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [31:0] sw(input logic [31:0] w);
        logic [31:0] o;
        for (int i = 0; i < 4; i++) o[8*i +: 8] = sb(w[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] sst(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 4; i++) o[32*i +: 32] = sw(s[32*i +: 32]);
        return o;
    endfunction

    function automatic logic [31:0] col_of(input logic [127:0] s, input int i);
        return s[127 - 32*i -: 32];
    endfunction

    always_comb sbo1 = sw(sbi1);
    always_comb sbo0 = sw(sbi0);

    sub_bytes_sched #(.KEY_PRIORITY(1'b1)) dut1 (
        .clk(clk), .rst(rst),
        .state_start(ss), .state_in(si), .state_ready(sr1), .state_done(sd1), .state_out(so1),
        .key_start(ks), .key_in(ki), .key_ready(kr1), .key_done(kd1), .key_out(ko1),
        .sbox_in(sbi1), .sbox_out(sbo1), .grant_state(gs1), .grant_key(gk1)
    );

    sub_bytes_sched #(.KEY_PRIORITY(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .state_start(ss), .state_in(si), .state_ready(sr0), .state_done(sd0), .state_out(so0),
        .key_start(ks), .key_in(ki), .key_ready(kr0), .key_done(kd0), .key_out(ko0),
        .sbox_in(sbi0), .sbox_out(sbo0), .grant_state(gs0), .grant_key(gk0)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, "_sr1"}, sr1, 1'b1);
        chk({tag, "_kr1"}, kr1, 1'b1);
        chk({tag, "_sd1"}, sd1, 1'b0);
        chk({tag, "_kd1"}, kd1, 1'b0);
        chk({tag, "_so1"}, so1, 128'h0);
        chk({tag, "_ko1"}, ko1, 32'h0);
        chk({tag, "_sbi1"}, sbi1, 32'h0);
        chk({tag, "_g1"}, {gs1, gk1}, 2'b00);
        chk({tag, "_sr0"}, sr0, 1'b1);
        chk({tag, "_so0"}, so0, 128'h0);
        chk({tag, "_sbi0"}, sbi0, 32'h0);
        chk({tag, "_g0"}, {gs0, gk0}, 2'b00);
    endtask

    // same-edge state and key requests; expected timing differs by priority
    task automatic both(input logic [127:0] s, input logic [31:0] k);
        si = s;
        ki = k;
        ss = 1'b1;
        ks = 1'b1;
        tick;
        ss = 1'b0;
        ks = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            chk("both_gk1", gk1, c == 1);
            chk("both_kd1", kd1, c == 2);
            chk("both_gs1", gs1, c >= 2 && c <= 5);
            chk("both_sd1", sd1, c == 6);
            chk("both_gs0", gs0, c <= 4);
            chk("both_sd0", sd0, c == 5);
            chk("both_gk0", gk0, c == 5);
            chk("both_kd0", kd0, c == 6);
            if (c == 2) chk("both_ko1", ko1, sw(k));
            if (c == 6) chk("both_so1", so1, sst(s));
            if (c == 5) chk("both_so0", so0, sst(s));
            if (c == 6) chk("both_ko0", ko0, sw(k));
            tick;
        end
    endtask

    initial begin
        logic [127:0] s0;
        logic [31:0]  kv [11];
        tick;
        idle_outputs("reset");
        tick;
        rst = 1'b0;
        tick;

        si = 128'h0;
        ss = 1'b1;
        tick;
        ss = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            chk("zero_gs1", gs1, c <= 4);
            chk("zero_gs0", gs0, c <= 4);
            chk("zero_sd1", sd1, c == 5);
            chk("zero_sd0", sd0, c == 5);
            if (c <= 4) chk("zero_sbi1", sbi1, col_of(si, c - 1));
            if (c >= 5) chk("zero_so1", so1, {16{8'h63}});
            if (c >= 5) chk("zero_so0", so0, {16{8'h63}});
            tick;
        end

        ki = 32'h00010253;
        ks = 1'b1;
        tick;
        ks = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            chk("key_gk1", gk1, c == 1);
            chk("key_kd1", kd1, c == 2);
            chk("key_sr1", sr1, 1'b1);
            chk("key_gk0", gk0, c == 1);
            chk("key_kd0", kd0, c == 2);
            chk("key_sr0", sr0, 1'b1);
            if (c >= 2) chk("key_ko1", ko1, 32'h637C77ED);
            if (c >= 2) chk("key_ko0", ko0, 32'h637C77ED);
            tick;
        end

        both({16{8'hFF}}, 32'h0);
        chk("ff_so1", so1, {16{8'h16}});
        chk("ff_so0", so0, {16{8'h16}});
        chk("ff_ko1", ko1, 32'h63636363);
        chk("ff_ko0", ko0, 32'h63636363);
        for (int r = 0; r < 3; r++)
            both({$urandom, $urandom, $urandom, $urandom}, $urandom);

        // keys offered every cycle during a state pass, extra state pulses while busy
        s0 = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 11; i++) kv[i] = $urandom;
        si = s0;
        ki = kv[0];
        ss = 1'b1;
        ks = 1'b1;
        tick;
        for (int c = 1; c <= 10; c++) begin
            chk("mix_gk1", gk1, c % 2 == 1 && c <= 9);
            chk("mix_gs1", gs1, c % 2 == 0 && c <= 8);
            chk("mix_sd1", sd1, c == 9);
            chk("mix_kd1", kd1, c % 2 == 0);
            if (gk1) chk("mix_sbi1k", sbi1, kv[c - 1]);
            if (c % 2 == 0 && c <= 8) chk("mix_sbi1s", sbi1, col_of(s0, c / 2 - 1));
            if (c % 2 == 0) chk("mix_ko1", ko1, sw(kv[c - 2]));
            if (c == 9) chk("mix_so1", so1, sst(s0));
            chk("mix_gs0", gs0, c <= 4);
            chk("mix_sd0", sd0, c == 5);
            chk("mix_gk0", gk0, c == 5 || c == 7 || c == 9);
            chk("mix_kd0", kd0, c == 6 || c == 8 || c == 10);
            if (c <= 4) chk("mix_sbi0s", sbi0, col_of(s0, c - 1));
            if (c == 5) chk("mix_sbi0k", sbi0, kv[0]);
            if (c == 7 || c == 9) chk("mix_sbi0k", sbi0, kv[c - 1]);
            if (c == 5) chk("mix_so0", so0, sst(s0));
            if (c == 6) chk("mix_ko0", ko0, sw(kv[0]));
            if (c == 8 || c == 10) chk("mix_ko0", ko0, sw(kv[c - 2]));
            ss = c <= 3;
            if (ss) si = {$urandom, $urandom, $urandom, $urandom};
            ks = c <= 9;
            ki = kv[c];
            tick;
        end
        ss = 1'b0;
        ks = 1'b0;
        tick;

        // asynchronous reset part-way through a pass
        si = {$urandom, $urandom, $urandom, $urandom};
        ss = 1'b1;
        tick;
        ss = 1'b0;
        tick;
        tick;
        chk("abort_gs1", gs1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        idle_outputs("abort");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk("abort_sd1", sd1, 1'b0);
            chk("abort_sd0", sd0, 1'b0);
            tick;
        end
        s0 = {$urandom, $urandom, $urandom, $urandom};
        si = s0;
        ss = 1'b1;
        tick;
        ss = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            chk("fresh_sd1", sd1, c == 5);
            chk("fresh_sd0", sd0, c == 5);
            if (c == 5) chk("fresh_so1", so1, sst(s0));
            if (c == 5) chk("fresh_so0", so0, sst(s0));
            tick;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
